// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the program-counter sequencer.
//   - Address and stall-bus widths, per-stage stall indices, PC step.
//   - stall_vector(): priority encoder that maps stage stall requests
//     onto the six-bit stall bus (latest requesting stage wins).
package pc_sequencer_pkg;

  localparam int ADDR_W  = 32;
  localparam int STALL_W = 6;

  // Bit positions on the stall bus, one per pipeline stage.
  localparam int STALL_PC  = 0;
  localparam int STALL_IF  = 1;
  localparam int STALL_ID  = 2;
  localparam int STALL_EX  = 3;
  localparam int STALL_MEM = 4;
  localparam int STALL_WB  = 5;

  localparam logic [ADDR_W-1:0] PC_STEP = 32'd4;

  // A stall in a later stage freezes every earlier stage as well, so the
  // vector is a thermometer code ending at the requesting stage. MEM and WB
  // are never frozen; they only receive bubbles.
  function automatic logic [STALL_W-1:0] stall_vector(input logic req_if,
                                                      input logic req_id,
                                                      input logic req_ex);
    logic [STALL_W-1:0] v;
    v = '0;
    if (req_ex) begin
      v[STALL_EX:STALL_PC] = '1;
    end else if (req_id) begin
      v[STALL_ID:STALL_PC] = '1;
    end else if (req_if) begin
      v[STALL_IF:STALL_PC] = '1;
    end
    v[STALL_MEM] = 1'b0;
    v[STALL_WB]  = 1'b0;
    return v;
  endfunction

endpackage

// File: rtl/pc_perf_counter.sv
// Performance counters for the PC sequencer.
// Ports:
//   clock        in   single clock, posedge
//   reset        in   synchronous, active-high; clears both counters
//   count_cycle  in   sequencer is out of reset: count this cycle
//   count_stall  in   PC is frozen this cycle
//   cycle_count  out  cycles spent outside reset (wraps)
//   stall_count  out  cycles with the PC frozen (wraps)
module pc_perf_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             count_cycle,
  input  logic             count_stall,
  output logic [WIDTH-1:0] cycle_count,
  output logic [WIDTH-1:0] stall_count
);

  always_ff @(posedge clock) begin
    if (reset) begin
      cycle_count <= '0;
      stall_count <= '0;
    end else begin
      if (count_cycle) cycle_count <= cycle_count + 1'b1;
      if (count_stall) stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: chooses the next fetch address (sequential,
// branch, exception), drives per-stage stall and pipeline flush controls, and
// holds a taken branch that resolves while instruction fetch is stalled.
// Optional feature macro: PC_SEQ_PERF_COUNTER_EN adds cycle/stall counters.
// Ports:
//   clock              in   single clock, posedge
//   reset              in   synchronous, active-high
//   stall_request_if   in   instruction memory not ready (freeze PC, IF)
//   stall_request_id   in   load-use hazard (freeze PC..ID)
//   stall_request_ex   in   multi-cycle EX op (freeze PC..EX)
//   branch_request     in   taken branch resolved in ID this cycle
//   branch_target      in   branch destination, valid with branch_request
//   exception_request  in   precise exception from MEM
//   program_counter    out  current fetch address (registered)
//   chip_enable        out  instruction memory enable (registered)
//   stall              out  [0]=PC [1]=IF [2]=ID [3]=EX [4]=MEM [5]=WB (comb.)
//   flush              out  one-cycle pulse clearing pipeline registers
//   branch_pending     out  a captured branch target awaits the PC
//   cycle_count        out  (PC_SEQ_PERF_COUNTER_EN) cycles out of reset
//   stall_count        out  (PC_SEQ_PERF_COUNTER_EN) cycles with PC frozen
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_VECTOR     = 32'h0000_0000,
  parameter logic [ADDR_W-1:0] EXCEPTION_VECTOR = 32'h0000_0020
`ifdef PC_SEQ_PERF_COUNTER_EN
  ,
  parameter int                COUNTER_WIDTH    = 32
`endif
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               stall_request_if,
  input  logic               stall_request_id,
  input  logic               stall_request_ex,
  input  logic               branch_request,
  input  logic [ADDR_W-1:0]  branch_target,
  input  logic               exception_request,
  output logic [ADDR_W-1:0]  program_counter,
  output logic               chip_enable,
  output logic [STALL_W-1:0] stall,
  output logic               flush,
  output logic               branch_pending
`ifdef PC_SEQ_PERF_COUNTER_EN
  ,
  output logic [COUNTER_WIDTH-1:0] cycle_count,
  output logic [COUNTER_WIDTH-1:0] stall_count
`endif
);

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_RUN   = 2'd1,
    S_WAIT  = 2'd2,
    S_FLUSH = 2'd3
  } state_e;

  state_e            state;
  logic [ADDR_W-1:0] pending_target;

  // Stall bus is forced quiet before the first fetch and during the flush
  // pulse: the pipeline is being emptied, so nothing may be frozen.
  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first so no
    // path through the block can leave it unassigned (which would be a latch).
    stall = '0;
    if (state != S_RESET && !flush) begin
      stall = stall_vector(stall_request_if, stall_request_id, stall_request_ex);
    end
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= S_RESET;
      program_counter <= RESET_VECTOR;
      chip_enable     <= 1'b0;
      flush           <= 1'b0;
      branch_pending  <= 1'b0;
      // NOTE: pending_target is a data register qualified by branch_pending,
      // so it is deliberately left out of reset.
    end else begin
      flush <= 1'b0;
      if (state == S_RESET) begin
        // PC already holds RESET_VECTOR, so the first fetch uses it.
        state       <= S_RUN;
        chip_enable <= 1'b1;
      end else if (exception_request) begin
        state           <= S_FLUSH;
        program_counter <= EXCEPTION_VECTOR;
        flush           <= 1'b1;
        branch_pending  <= 1'b0;
      end else begin
        case (state)
          S_RUN:   if (stall_request_if) state <= S_WAIT;
          S_WAIT:  if (!stall_request_if) state <= S_RUN;
          default: state <= S_RUN;
        endcase

        if (stall[STALL_PC]) begin
          // Only an IF-only stall lets ID retire the branch; a frozen ID will
          // present the same branch again once it is released.
          if (branch_request && !stall[STALL_ID]) begin
            pending_target <= branch_target;
            branch_pending <= 1'b1;
          end
        end else if (branch_pending) begin
          program_counter <= pending_target;
          branch_pending  <= 1'b0;
        end else if (branch_request) begin
          program_counter <= branch_target;
        end else begin
          program_counter <= program_counter + PC_STEP;
        end
      end
    end
  end

`ifdef PC_SEQ_PERF_COUNTER_EN
  pc_perf_counter #(
    .WIDTH (COUNTER_WIDTH)
  ) u_perf (
    .clock       (clock),
    .reset       (reset),
    .count_cycle (state != S_RESET),
    .count_stall (stall[STALL_PC]),
    .cycle_count (cycle_count),
    .stall_count (stall_count)
  );
`endif

endmodule
